incr_stream_driver_checker: RTL and testbench

Drives the 8-bit valid/data stream into the increment stage and checks the returned stream against the expected value of input+1 mod 256. It sits on the far side of the increment stage: its stream_* outputs feed the stage input, and the stage output returns on ret_*. Expected values wait in a small in-order FIFO. The block reports pass/fail, an error count, the first mismatch, and a timeout flag.

---
 rtl/incr_stream_driver_checker.sv | 179 +++++++++++++++++
 tb/tb_incr_stream_driver_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/incr_stream_driver_checker.sv
// Drives an 8-bit valid/data stream into an increment stage and checks that
// each returned word equals sent+1 mod 256, in order, via a small expected FIFO.
module incr_stream_driver_checker #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic [7:0] num_words,
  output logic       stream_valid,
  output logic [7:0] stream_data,
  input  logic       ret_valid,
  input  logic [7:0] ret_data,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_err_exp,
  output logic [7:0] first_err_got,
  output logic       timeout,
  output logic [1:0] fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [7:0]      seed_q;
  logic [7:0]      num_q;
  logic [7:0]      idx;
  logic [IW-1:0]   idle_cnt;
  logic            first_seen;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic       fifo_full, fifo_empty, ret_active, pop, push, unexpected, mismatch;
  logic       start_acc, drain_empty, last_word, flush;
  logic [7:0] send_data, err_base, err_next;

  // Neither stream has backpressure: every cycle with stream_valid high is one
  // outbound word, every cycle with ret_valid high is one returned word.
  assign fifo_full   = (count == DEPTH_C);
  assign fifo_empty  = (count == '0);
  assign ret_active  = (state == ST_SEND) || (state == ST_DRAIN);
  assign pop         = ret_valid && ret_active && !fifo_empty;
  assign unexpected  = ret_valid && !pop;
  assign mismatch    = pop && (mem[rd_ptr] != ret_data);
  assign start_acc   = start && (state == ST_IDLE);
  assign push        = (state == ST_SEND) && !fifo_full;
  assign send_data   = seed_q + idx;
  assign last_word   = (idx == num_q - 8'd1);
  assign drain_empty = fifo_empty || (pop && (count == CW'(1)));
  assign flush       = (state == ST_DRAIN) && !drain_empty && !ret_valid &&
                       (idle_cnt == IDLE_LAST);

  assign busy      = ret_active;
  assign fsm_state = state;

  // A start in the same cycle as a stray return clears first, then counts it.
  always_comb begin
    err_base = start_acc ? 8'd0 : err_count;
    err_next = err_base;
    if ((mismatch || unexpected) && (err_base != 8'hFF)) err_next = err_base + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= send_data + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      seed_q        <= '0;
      num_q         <= '0;
      idx           <= '0;
      idle_cnt      <= '0;
      first_seen    <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      stream_valid  <= 1'b0;
      stream_data   <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
      timeout       <= 1'b0;
    end else begin
      done      <= 1'b0;
      err_count <= err_next;

      if (mismatch && !first_seen) begin
        first_seen    <= 1'b1;
        first_err_exp <= mem[rd_ptr];
        first_err_got <= ret_data;
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      case (state)
        ST_IDLE: begin
          stream_valid <= 1'b0;
          if (start_acc) begin
            seed_q        <= seed;
            num_q         <= num_words;
            idx           <= '0;
            timeout       <= 1'b0;
            pass          <= 1'b0;
            first_seen    <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
            state         <= (num_words != 8'd0) ? ST_SEND : ST_DONE;
          end
        end
        ST_SEND: begin
          stream_valid <= push;
          if (push) begin
            stream_data <= send_data;
            if (last_word) begin
              idle_cnt <= '0;
              state    <= ST_DRAIN;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        ST_DRAIN: begin
          stream_valid <= 1'b0;
          if (drain_empty) begin
            state <= ST_DONE;
          end else if (ret_valid) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            // Outstanding entries are dropped without touching err_count.
            timeout <= 1'b1;
            state   <= ST_DONE;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        ST_DONE: begin
          stream_valid <= 1'b0;
          done         <= 1'b1;
          pass         <= (err_next == 8'd0) && !timeout;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_incr_stream_driver_checker.sv
// Bench for incr_stream_driver_checker: models the increment stage with random
// return timing and scores the checker's verdict against an independent model.
module tb_incr_stream_driver_checker;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] seed;
  logic [7:0] num_words;
  logic       stream_valid;
  logic [7:0] stream_data;
  logic       ret_valid;
  logic [7:0] ret_data;
  logic       busy, done, pass, timeout;
  logic [7:0] err_count, first_err_exp, first_err_got;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] stage_q[$];

  int r_first_sv, r_last_sv, r_done_cyc, r_snap_a, r_snap_b, r_max_out, r_sent;

  incr_stream_driver_checker #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .seed(seed), .num_words(num_words),
    .stream_valid(stream_valid), .stream_data(stream_data),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got),
    .timeout(timeout), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run: the bench plays the increment stage, returning queued words +1
  // (optionally corrupting one) while the expected queue scores each return.
  task automatic run(input logic [7:0] s, input int n, input int prob, input int ret_limit,
                     input int corrupt_idx, input logic [7:0] corrupt_val,
                     input int hold_until, input int single_at);
    int sent, returned, model_err, done_cnt, gap;
    bit have_first, exp_to, exp_pass;
    logic [7:0] m_first_exp, m_first_got, w, e;
    logic [7:0] got_err, got_fexp, got_fgot;
    logic got_pass, got_to;
    sent = 0; returned = 0; model_err = 0; done_cnt = 0; gap = 0;
    have_first = 0; m_first_exp = 0; m_first_got = 0;
    got_err = 0; got_fexp = 0; got_fgot = 0; got_pass = 0; got_to = 0;
    r_first_sv = -1; r_last_sv = -1; r_done_cyc = -1; r_snap_a = -1; r_snap_b = -1;
    r_max_out = 0;
    exp_q.delete();
    stage_q.delete();
    @(negedge clk);
    seed = s; num_words = n[7:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      if (cyc == single_at) r_snap_a = sent;
      if (cyc == hold_until) r_snap_b = sent;
      if (stream_valid) begin
        w = s + 8'(sent);
        check("stream_data", {24'd0, stream_data}, {24'd0, w});
        exp_q.push_back(w + 8'd1);
        stage_q.push_back(stream_data);
        if (r_first_sv < 0) r_first_sv = cyc;
        r_last_sv = cyc;
        sent++;
      end
      if (sent - returned > r_max_out) r_max_out = sent - returned;
      if (done) begin
        done_cnt++;
        r_done_cyc = cyc;
        got_pass = pass; got_err = err_count; got_to = timeout;
        got_fexp = first_err_exp; got_fgot = first_err_got;
      end
      if (stage_q.size() > 0 && returned < ret_limit &&
          ((cyc >= hold_until && ($urandom_range(99) < prob || gap >= 8)) || cyc == single_at)) begin
        w = stage_q.pop_front() + 8'd1;
        if (returned == corrupt_idx) w = corrupt_val;
        e = exp_q.pop_front();
        if (w != e) begin
          model_err++;
          if (!have_first) begin
            have_first = 1; m_first_exp = e; m_first_got = w;
          end
        end
        ret_valid = 1'b1;
        ret_data  = w;
        returned++;
        gap = 0;
      end else begin
        ret_valid = 1'b0;
        ret_data  = 8'($urandom);
        gap++;
      end
      if (done_cnt > 0 && cyc >= r_done_cyc + 2) break;
      @(negedge clk);
    end
    ret_valid = 1'b0;
    r_sent = sent;
    exp_to   = (ret_limit < n);
    exp_pass = (model_err == 0) && !exp_to;
    check("done_pulses", done_cnt, 1);
    check("words_sent", sent, n);
    check("outstanding_bound", (r_max_out <= DEPTH), 1);
    check("err_count", {24'd0, got_err}, model_err);
    check("timeout", {31'd0, got_to}, {31'd0, exp_to});
    check("pass", {31'd0, got_pass}, {31'd0, exp_pass});
    check("first_err_exp", {24'd0, got_fexp}, {24'd0, m_first_exp});
    check("first_err_got", {24'd0, got_fgot}, {24'd0, m_first_got});
    check("busy_after", {31'd0, busy}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; seed = '0; num_words = '0;
    ret_valid = 1'b0; ret_data = '0;
    repeat (3) @(negedge clk);
    check("rst_stream_valid", {31'd0, stream_valid}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pass", {31'd0, pass}, 0);
    check("rst_err_count", {24'd0, err_count}, 0);
    check("rst_first_err", {16'd0, first_err_exp, first_err_got}, 0);
    check("rst_timeout_busy", {30'd0, timeout, busy}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Straight loopback: four back-to-back words.
    run(8'h10, 4, 100, 999, -1, 8'h00, 0, -1);
    check("loop_back_to_back", r_last_sv - r_first_sv, 3);

    // Data wrap across 0xFF.
    run(8'hFE, 3, 100, 999, -1, 8'h00, 0, -1);

    // Word 2 corrupted to 0x55.
    run(8'h10, 4, 100, 999, 2, 8'h55, 0, -1);
    check("corrupt_first_exp", {24'd0, first_err_exp}, 32'h13);
    check("corrupt_first_got", {24'd0, first_err_got}, 32'h55);
    check("corrupt_err_count", {24'd0, err_count}, 1);

    // Returns held off: FIFO fills at DEPTH, one return lets exactly one more out.
    run(8'h20, 8, 100, 999, -1, 8'h00, 14, 10);
    check("stall_sent_at_full", r_snap_a, DEPTH);
    check("stall_one_more", r_snap_b, DEPTH + 1);
    check("stall_max_out", r_max_out, DEPTH);

    // No returns: DRAIN times out after TIMEOUT idle cycles.
    run(8'h40, 2, 100, 0, -1, 8'h00, 0, -1);
    check("timeout_drain_len", r_done_cyc - r_last_sv, TMO + 1);
    @(negedge clk);
    ret_valid = 1'b1; ret_data = 8'h41;
    @(negedge clk);
    ret_valid = 1'b0;
    check("idle_unexpected_err", {24'd0, err_count}, 1);
    check("idle_timeout_held", {31'd0, timeout}, 1);

    // Maximum length run.
    run(8'($urandom), 255, 100, 999, -1, 8'h00, 0, -1);

    repeat (12) begin
      int n, ci;
      n  = $urandom_range(1, 40);
      ci = ($urandom_range(1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
      run(8'($urandom), n, $urandom_range(40, 100), 999, ci, 8'($urandom), 0, -1);
    end

    // Asynchronous reset in the middle of SEND.
    @(negedge clk);
    seed = 8'h33; num_words = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_streaming", {30'd0, stream_valid, busy}, 32'h3);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_stream", {31'd0, stream_valid}, 0);
    check("mid_rst_busy_done", {30'd0, busy, done}, 0);
    check("mid_rst_status", {23'd0, pass, timeout, err_count}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", {31'd0, done}, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Zero-length run after reset.
    run(8'h00, 0, 100, 999, -1, 8'h00, 0, -1);
    check("zero_done_latency", r_done_cyc, 2);
    check("zero_no_stream", r_first_sv, -1);
    check("zero_pass", {31'd0, pass}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
